// File: rtl/base64_pkg.sv
// Shared types and helpers for the streaming Base64 encoder.
//   state_t   : encoder FSM states
//   ASCII_*   : pad / line-break characters
//   b64_char  : 6-bit index + alphabet select -> ASCII character
package base64_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    EMIT    = 2'd1,
    CR      = 2'd2,
    LF      = 2'd3
  } state_t;

  localparam logic [7:0] ASCII_PAD = 8'h3D;  // '='
  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_LF  = 8'h0A;

  // url_safe=1 swaps '+' '/' for '-' '_' on indices 62/63.
  function automatic logic [7:0] b64_char(input logic [5:0] idx, input logic url_safe);
    logic [7:0] i8;
    i8 = {2'b00, idx};
    if (idx < 6'd26)      return 8'h41 + i8;
    else if (idx < 6'd52) return 8'h61 + i8 - 8'd26;
    else if (idx < 6'd62) return 8'h30 + i8 - 8'd52;
    else if (idx == 6'd62) return url_safe ? 8'h2D : 8'h2B;
    else                   return url_safe ? 8'h5F : 8'h2F;
  endfunction

endpackage

// File: rtl/base64_sextet_map.sv
// Combinational Base64 alphabet lookup.
//   idx   : 6-bit sextet value
//   ascii : encoded character (alphabet chosen by URL_SAFE)
module base64_sextet_map
  import base64_pkg::*;
#(
  parameter bit URL_SAFE = 1'b0
) (
  input  logic [5:0] idx,
  output logic [7:0] ascii
);

  assign ascii = b64_char(idx, URL_SAFE);

endmodule

// File: rtl/base64_stream_enc.sv
// Streaming Base64 encoder. Collects up to three bytes per group from a
// valid/ready byte stream, then emits four (or fewer, without padding)
// ASCII characters one per handshake, with optional CR/LF every LINE_LEN
// characters. Input and output phases never overlap.
//   clk, rst_n                 : clock, async active-low reset
//   s_data/s_valid/s_last/s_ready : byte input stream, s_last closes a frame
//   m_data/m_valid/m_last/m_ready : character output stream, m_last on final char
//   busy                       : frame in progress (first byte .. final char)
module base64_stream_enc
  import base64_pkg::*;
#(
  parameter bit          URL_SAFE = 1'b0,
  parameter bit          PAD      = 1'b1,
  parameter int unsigned LINE_LEN = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] m_data,
  output logic       m_valid,
  output logic       m_last,
  input  logic       m_ready,
  output logic       busy
);

  localparam logic [7:0] LINE_LEN8 = 8'(LINE_LEN);

  state_t      state, state_nxt;
  logic [23:0] grp_buf;
  logic [1:0]  cnt;
  logic [1:0]  nbytes;
  logic        grp_last;
  logic [1:0]  ci;
  logic [7:0]  line_cnt;

  logic        s_acc, m_acc;
  logic        grp_close;
  logic        grp_done;
  logic [1:0]  last_ci;
  logic [5:0]  sextet;
  logic [7:0]  map_char;
  logic [7:0]  data_char;
  logic [7:0]  line_next;

  assign s_acc     = s_valid & s_ready;
  assign m_acc     = m_valid & m_ready;
  assign grp_close = (cnt == 2'd2) | s_last;
  // Without padding the group stops at the last character carrying data bits.
  assign last_ci   = PAD ? 2'd3 : nbytes;
  assign grp_done  = (ci == last_ci);
  assign line_next = line_cnt + 8'd1;

  always_comb begin
    sextet = grp_buf[23:18];
    case (ci)
      2'd0: sextet = grp_buf[23:18];
      2'd1: sextet = grp_buf[17:12];
      2'd2: sextet = grp_buf[11:6];
      2'd3: sextet = grp_buf[5:0];
      default: sextet = grp_buf[23:18];
    endcase
  end

  base64_sextet_map #(.URL_SAFE(URL_SAFE)) u_map (
    .idx   (sextet),
    .ascii (map_char)
  );

  // Characters past the data-carrying ones are pad; only reachable with PAD=1.
  assign data_char = (ci > nbytes) ? ASCII_PAD : map_char;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= COLLECT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    m_valid   = 1'b0;
    m_data    = 8'h00;
    m_last    = 1'b0;
    case (state)
      COLLECT: begin
        s_ready = 1'b1;
        if (s_acc && grp_close) state_nxt = EMIT;
      end
      EMIT: begin
        m_valid = 1'b1;
        m_data  = data_char;
        m_last  = grp_last & grp_done;
        if (m_acc && grp_done) begin
          // line_next is the count including this character.
          if (grp_last)                                   state_nxt = COLLECT;
          else if (LINE_LEN != 0 && line_next == LINE_LEN8) state_nxt = CR;
          else                                            state_nxt = COLLECT;
        end
      end
      CR: begin
        m_valid = 1'b1;
        m_data  = ASCII_CR;
        if (m_acc) state_nxt = LF;
      end
      LF: begin
        m_valid = 1'b1;
        m_data  = ASCII_LF;
        if (m_acc) state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grp_buf  <= '0;
      cnt      <= '0;
      nbytes   <= '0;
      grp_last <= 1'b0;
      ci       <= '0;
      line_cnt <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        COLLECT: if (s_acc) begin
          busy <= 1'b1;
          // Each write also zeroes the bytes after it, so a short final
          // group never carries stale data from an earlier group.
          case (cnt)
            2'd0:    grp_buf <= {s_data, 16'h0000};
            2'd1:    grp_buf <= {grp_buf[23:16], s_data, 8'h00};
            default: grp_buf <= {grp_buf[23:8], s_data};
          endcase
          if (grp_close) begin
            nbytes   <= cnt + 2'd1;
            grp_last <= s_last;
            cnt      <= '0;
            ci       <= '0;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        EMIT: if (m_acc) begin
          ci       <= ci + 2'd1;
          line_cnt <= line_next;
          if (grp_done && grp_last) begin
            line_cnt <= '0;
            busy     <= 1'b0;
          end
        end
        LF: if (m_acc) line_cnt <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_base64_stream_enc.sv
module tb_base64_stream_enc;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: defaults, 1: URL-safe, 2: no padding, 3: LINE_LEN=4
  logic [7:0] s_data [4];
  logic       s_valid[4];
  logic       s_last [4];
  logic       s_ready[4];
  logic [7:0] m_data [4];
  logic       m_valid[4];
  logic       m_last [4];
  logic       m_ready[4];
  logic       busy   [4];

  base64_stream_enc #(.URL_SAFE(1'b0), .PAD(1'b1), .LINE_LEN(0)) u_def (
    .clk(clk), .rst_n(rst_n), .s_data(s_data[0]), .s_valid(s_valid[0]), .s_last(s_last[0]),
    .s_ready(s_ready[0]), .m_data(m_data[0]), .m_valid(m_valid[0]), .m_last(m_last[0]),
    .m_ready(m_ready[0]), .busy(busy[0]));
  base64_stream_enc #(.URL_SAFE(1'b1), .PAD(1'b1), .LINE_LEN(0)) u_url (
    .clk(clk), .rst_n(rst_n), .s_data(s_data[1]), .s_valid(s_valid[1]), .s_last(s_last[1]),
    .s_ready(s_ready[1]), .m_data(m_data[1]), .m_valid(m_valid[1]), .m_last(m_last[1]),
    .m_ready(m_ready[1]), .busy(busy[1]));
  base64_stream_enc #(.URL_SAFE(1'b0), .PAD(1'b0), .LINE_LEN(0)) u_nopad (
    .clk(clk), .rst_n(rst_n), .s_data(s_data[2]), .s_valid(s_valid[2]), .s_last(s_last[2]),
    .s_ready(s_ready[2]), .m_data(m_data[2]), .m_valid(m_valid[2]), .m_last(m_last[2]),
    .m_ready(m_ready[2]), .busy(busy[2]));
  base64_stream_enc #(.URL_SAFE(1'b0), .PAD(1'b1), .LINE_LEN(4)) u_line (
    .clk(clk), .rst_n(rst_n), .s_data(s_data[3]), .s_valid(s_valid[3]), .s_last(s_last[3]),
    .s_ready(s_ready[3]), .m_data(m_data[3]), .m_valid(m_valid[3]), .m_last(m_last[3]),
    .m_ready(m_ready[3]), .busy(busy[3]));

  int         checks = 0;
  int         failures = 0;
  logic [7:0] got_d[16];
  logic       got_l[16];
  int         got_n;
  logic       busy_end;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bytes are taken MSB-first from din; optional random idle cycles between bytes.
  task automatic send(input int u, input logic [47:0] din, input int nin, input bit gap);
    int cyc;
    for (int i = 0; i < nin; i++) begin
      if (gap) begin
        @(negedge clk);
        s_valid[u] = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      @(negedge clk);
      s_valid[u] = 1'b1;
      s_data[u]  = din[8*(nin-1-i) +: 8];
      s_last[u]  = (i == nin - 1);
      cyc = 0;
      while (!s_ready[u] && cyc < 400) begin
        @(negedge clk);
        cyc++;
      end
      chk("send_accept", 32'(cyc < 400), 32'd1);
      @(posedge clk);
    end
    @(negedge clk);
    s_valid[u] = 1'b0;
    s_last[u]  = 1'b0;
  endtask

  // Collects n characters; with stall, m_ready is random and held outputs are checked.
  task automatic recv(input int u, input int n, input bit stall);
    int         cyc;
    logic       hv;
    logic [7:0] hd;
    logic       hl;
    cyc = 0; hv = 1'b0; hd = 8'h00; hl = 1'b0;
    got_n = 0;
    while (got_n < n && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (hv) begin
        chk("stall_hold_valid", 32'(m_valid[u]), 32'd1);
        chk("stall_hold_data", 32'(m_data[u]), 32'(hd));
        chk("stall_hold_last", 32'(m_last[u]), 32'(hl));
      end
      m_ready[u] = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      hv = m_valid[u] && !m_ready[u];
      hd = m_data[u];
      hl = m_last[u];
      if (m_valid[u] && m_ready[u]) begin
        if (got_n == 0) chk("busy_mid", 32'(busy[u]), 32'd1);
        got_d[got_n] = m_data[u];
        got_l[got_n] = m_last[u];
        got_n++;
      end
    end
    @(negedge clk);
    m_ready[u] = 1'b0;
    busy_end = busy[u];
  endtask

  task automatic run(input string tag, input int u, input logic [47:0] din, input int nin,
                     input logic [79:0] exp, input int nexp, input bit stall, input bit gap);
    fork
      send(u, din, nin, gap);
      recv(u, nexp, stall);
    join
    chk($sformatf("%s_count", tag), 32'(got_n), 32'(nexp));
    for (int i = 0; i < nexp && i < got_n; i++) begin
      chk($sformatf("%s_char%0d", tag, i), 32'(got_d[i]), 32'(exp[8*(nexp-1-i) +: 8]));
      chk($sformatf("%s_last%0d", tag, i), 32'(got_l[i]), 32'(i == nexp - 1));
    end
    chk($sformatf("%s_busy_end", tag), 32'(busy_end), 32'd0);
    // A trailing CR/LF or extra character would show up as m_valid here.
    chk($sformatf("%s_idle", tag), 32'(m_valid[u]), 32'd0);
  endtask

  task automatic chk_reset(input string tag);
    for (int u = 0; u < 4; u++) begin
      chk($sformatf("%s_s_ready%0d", tag, u), 32'(s_ready[u]), 32'd1);
      chk($sformatf("%s_m_valid%0d", tag, u), 32'(m_valid[u]), 32'd0);
      chk($sformatf("%s_m_data%0d", tag, u), 32'(m_data[u]), 32'd0);
      chk($sformatf("%s_m_last%0d", tag, u), 32'(m_last[u]), 32'd0);
      chk($sformatf("%s_busy%0d", tag, u), 32'(busy[u]), 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int u = 0; u < 4; u++) begin
      s_data[u] = 8'h00; s_valid[u] = 1'b0; s_last[u] = 1'b0; m_ready[u] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // "Man" -> "TWFu"
    run("man", 0, 48'h4D616E, 3, 80'h54574675, 4, 1'b0, 1'b0);
    // "Ma" -> "TWE=", "M" -> "TQ=="
    run("ma", 0, 48'h4D61, 2, 80'h5457453D, 4, 1'b0, 1'b0);
    run("m", 0, 48'h4D, 1, 80'h54513D3D, 4, 1'b0, 1'b0);
    // No padding: "M" -> "TQ"
    run("m_nopad", 2, 48'h4D, 1, 80'h5451, 2, 1'b0, 1'b0);
    run("ma_nopad", 2, 48'h4D61, 2, 80'h545745, 3, 1'b0, 1'b0);
    // Indices 62/63 in both alphabets
    run("fbff_std", 0, 48'hFBFF, 2, 80'h2B2F383D, 4, 1'b0, 1'b0);
    run("fbff_url", 1, 48'hFBFF, 2, 80'h2D5F383D, 4, 1'b0, 1'b0);
    // Line break between groups but not after the final group
    run("line_manman", 3, 48'h4D616E4D616E, 6, 80'h545746750D0A54574675, 10, 1'b0, 1'b0);
    run("line_man", 3, 48'h4D616E, 3, 80'h54574675, 4, 1'b0, 1'b0);
    run("line_manman_stall", 3, 48'h4D616E4D616E, 6, 80'h545746750D0A54574675, 10, 1'b1, 1'b1);
    // Back-pressure and input gaps
    run("man_stall", 0, 48'h4D616E, 3, 80'h54574675, 4, 1'b1, 1'b0);
    run("man_gap", 0, 48'h4D616E, 3, 80'h54574675, 4, 1'b0, 1'b1);

    // Reset after two characters of "TWFu"
    fork
      send(0, 48'h4D616E, 3, 1'b0);
      recv(0, 2, 1'b0);
    join
    chk("rst_pre_count", 32'(got_n), 32'd2);
    chk("rst_pre_char0", 32'(got_d[0]), 32'h54);
    chk("rst_pre_char1", 32'(got_d[1]), 32'h57);
    chk("rst_pre_busy", 32'(busy[0]), 32'd1);
    chk("rst_pre_valid", 32'(m_valid[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset("postreset");
    run("rst_ma", 0, 48'h4D61, 2, 80'h5457453D, 4, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/base64_stream_enc.md
# base64_stream_enc

Streaming Base64 encoder for the UART-to-IoT path. Accepts a framed byte stream over a valid/ready handshake, packs bytes into 24-bit groups and emits the encoded ASCII characters one per cycle over a second valid/ready handshake. It handles partial final groups with optional '=' padding, selects the standard or URL-safe alphabet, and optionally inserts CR/LF line breaks. It replaces the fixed 24-bit, single-shot transform wrapper with a frame-aware, back-pressured engine.

## Interface
- URL_SAFE, 0: 0 selects '+' '/' for indices 62/63; 1 selects '-' '_'.
- PAD, 1: 1 pads a partial final group with '=' to 4 characters; 0 omits the pad characters.
- LINE_LEN, 0: characters per output line. 0 disables line breaks. Otherwise a multiple of 4 in the range 4..252.
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- s_data  in  8  input byte
- s_valid  in  1  input byte valid
- s_last  in  1  marks the final byte of a frame
- s_ready  out  1  encoder can accept a byte
- m_data  out  8  output ASCII character
- m_valid  out  1  output character valid
- m_last  out  1  marks the final character of a frame
- m_ready  in  1  downstream accepts the character
- busy  out  1  high from the first accepted byte of a frame until its final character is accepted

## Operation
- States:
  - COLLECT: s_ready=1. A byte is accepted when s_valid&s_ready. Byte k (k=0..2) goes to buf[23-8k:16-8k]. A byte counter runs 0..2.
  - Leave COLLECT for EMIT on the accepted byte when cnt==2 or s_last=1. On that transition, latch nbytes=cnt+1 and grp_last=s_last, zero the unfilled buffer bytes, and clear cnt.
  - EMIT: s_ready=0. A character index ci runs 0..3. Character ci encodes sextet buf[23-6ci:18-6ci].
  - For ci>nbytes the character is '=' when PAD=1. When PAD=0, the group ends after character ci=nbytes.
  - ci advances on m_valid&m_ready.
- After the last character of a group:
  - If grp_last=1: go to COLLECT, clear the line counter and busy.
  - Else if LINE_LEN!=0 and line_cnt==LINE_LEN: go to CR.
  - Else: go to COLLECT.
- CR emits 0x0D, then LF emits 0x0A. Each advances on handshake. LF returns to COLLECT and clears line_cnt.
- line_cnt (8 bits) increments per accepted data or pad character. It is never incremented by CR/LF.
- No line break is ever inserted after the final group of a frame.
- m_last=1 only on the final data or pad character of a frame.
- Alphabet mapping:
  - 0-25 → 'A'-'Z'
  - 26-51 → 'a'-'z'
  - 52-61 → '0'-'9'
  - 62/63 → per URL_SAFE
- Every frame carries at least one byte. s_last on any byte closes the frame.

## Timing
- Reset values: state=COLLECT, s_ready=1, m_valid=0, m_data=0x00, m_last=0, busy=0, all counters and buffers 0.
- Reset mid-frame discards buffered bytes and any partially emitted group. No m_last is produced.
- Latency: the third byte (or the s_last byte) is accepted at edge N. The first character is valid in the cycle after edge N.
- Throughput: with m_ready held high, one full group costs 3 input cycles plus 4 output cycles. Input and output do not overlap.
- While m_valid=1 and m_ready=0, m_data, m_last and the state hold stable.
- s_data is ignored while s_ready=0. The upstream must hold s_valid/s_data until accepted.
- busy rises in the cycle after the first byte of a frame is accepted. It falls in the cycle after the m_last handshake.

## Structure
- Package base64_pkg holds:
  - state enum (COLLECT, EMIT, CR, LF)
  - ASCII constants for '=', CR, LF
  - the function mapping a 6-bit index and a url_safe flag to ASCII
- Sub-module base64_sextet_map is combinational: 6-bit index in, 8-bit ASCII out, URL_SAFE parameter. It is instantiated once, driven by the sextet selected by ci.

## Test plan
- "Man" (4D 61 6E, last on 6E), PAD=1 → "TWFu" (54 57 46 75), m_last on 75, busy low afterwards.
- "Ma" last on 61 → "TWE="; "M" last on 4D → "TQ==". With PAD=0, "M" → "TQ" with m_last on 'Q'.
- FB FF last, URL_SAFE=0 → "+/8="; URL_SAFE=1 → "-_8=".
- LINE_LEN=4, "ManMan" (last on final 6E) → "TWFu" 0D 0A "TWFu". No trailing CR/LF; m_last on the final 'u'.
- Random m_ready stalls on "Man": output sequence unchanged and m_data stable during every stall. Random s_valid gaps: same output.
- Assert rst_n low after 2 chars of "TWFu": outputs return to reset values. A following "Ma" frame → "TWE=" correctly, with no stale bytes.
